// File: rtl/frame_burst_sequencer.sv
// frame_burst_sequencer: walks one frame as lines x (full bursts + optional
// tail), issues one burst command per step over valid/ready, and emits the
// single-cycle strobes the address generator consumes after each burst.
module frame_burst_sequencer #(
    parameter int LSIZE       = 12,
    parameter int BSIZE       = 12,
    parameter int LENSIZE     = 8,
    parameter int BURST_LEN   = 64,
    parameter int ADDR_SETTLE = 3
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               enable,
    input  logic               frame_start,
    input  logic [LSIZE-1:0]   lines,
    input  logic [BSIZE-1:0]   bursts_per_line,
    input  logic [LENSIZE-1:0] tail_len,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [LENSIZE-1:0] cmd_len,
    output logic               cmd_last_line,
    output logic               cmd_last_frame,
    input  logic               burst_resp,
    output logic               new_base,
    output logic               burst_done,
    output logic               tail_done,
    output logic               frame_done,
    output logic               busy
);

    localparam int SW = (ADDR_SETTLE > 1) ? $clog2(ADDR_SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_BASE, S_ISSUE, S_WAIT, S_STROBE, S_SETTLE, S_FEND
    } state_t;

    state_t             state, state_nxt;
    logic [LSIZE-1:0]   lines_q, line_cnt, line_src;
    logic [BSIZE-1:0]   bpl_q;
    logic [LENSIZE-1:0] tail_q, src_len;
    logic [BSIZE:0]     burst_cnt, burst_src, n_bursts;
    logic [SW-1:0]      settle_cnt;
    logic               raised;
    logic               frame_empty, src_last_line, src_last_frame;

    assign n_bursts    = {1'b0, bpl_q} + (BSIZE+1)'(tail_q != '0);
    assign frame_empty = (lines_q == '0) || (n_bursts == '0);

    // Position of the next command: origin in BASE, one step ahead in STROBE.
    always_comb begin
        line_src  = '0;
        burst_src = '0;
        if (state == S_STROBE) begin
            if (cmd_last_line) begin
                line_src = line_cnt + LSIZE'(1);
            end else begin
                line_src  = line_cnt;
                burst_src = burst_cnt + (BSIZE+1)'(1);
            end
        end
        src_last_line  = (burst_src == n_bursts - (BSIZE+1)'(1));
        src_last_frame = src_last_line && (line_src == lines_q - LSIZE'(1));
        src_len        = (tail_q != '0 && src_last_line) ? tail_q : LENSIZE'(BURST_LEN);
    end

    // State register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state and decoded outputs.
    always_comb begin
        state_nxt  = state;
        cmd_valid  = 1'b0;
        new_base   = 1'b0;
        burst_done = 1'b0;
        tail_done  = 1'b0;
        frame_done = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE:   if (frame_start) state_nxt = S_BASE;
            S_BASE: begin
                new_base  = 1'b1;
                state_nxt = frame_empty ? S_FEND : S_ISSUE;
            end
            S_ISSUE: begin
                // once raised, valid holds until accepted regardless of enable
                cmd_valid = enable || raised;
                if (cmd_valid && cmd_ready) state_nxt = S_WAIT;
            end
            S_WAIT:   if (burst_resp) state_nxt = S_STROBE;
            S_STROBE: begin
                tail_done  = cmd_last_line;
                burst_done = !cmd_last_line;
                state_nxt  = cmd_last_frame ? S_FEND : S_SETTLE;
            end
            S_SETTLE: if (settle_cnt == SW'(ADDR_SETTLE - 1)) state_nxt = S_ISSUE;
            S_FEND: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Frame parameters, walk counters and registered command fields.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            lines_q        <= '0;
            bpl_q          <= '0;
            tail_q         <= '0;
            line_cnt       <= '0;
            burst_cnt      <= '0;
            cmd_len        <= '0;
            cmd_last_line  <= 1'b0;
            cmd_last_frame <= 1'b0;
        end else begin
            if (state == S_IDLE && frame_start) begin
                lines_q <= lines;
                bpl_q   <= bursts_per_line;
                tail_q  <= tail_len;
            end
            if (state == S_BASE || state == S_STROBE) begin
                line_cnt       <= line_src;
                burst_cnt      <= burst_src;
                cmd_len        <= src_len;
                cmd_last_line  <= src_last_line;
                cmd_last_frame <= src_last_frame;
            end
        end
    end

    // Settle timer and the sticky-valid flag.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            raised     <= 1'b0;
        end else begin
            if (state == S_STROBE)      settle_cnt <= '0;
            else if (state == S_SETTLE) settle_cnt <= settle_cnt + SW'(1);
            raised <= (state == S_ISSUE) && cmd_valid && !cmd_ready;
        end
    end

endmodule

// File: tb/tb_frame_burst_sequencer.sv
// Scoreboard bench for frame_burst_sequencer: stimulus pushes expected commands
// and strobes from a loop-level frame model; a monitor pops and compares.
module tb_frame_burst_sequencer;

    localparam int LSIZE = 12, BSIZE = 12, LENSIZE = 8, BURST_LEN = 64, AS = 3;

    logic clock = 0, rst = 1, enable = 0, frame_start = 0;
    logic [LSIZE-1:0]   lines = '0;
    logic [BSIZE-1:0]   bursts_per_line = '0;
    logic [LENSIZE-1:0] tail_len = '0;
    logic cmd_ready = 0, burst_resp = 0;
    logic cmd_valid, cmd_last_line, cmd_last_frame;
    logic new_base, burst_done, tail_done, frame_done, busy;
    logic [LENSIZE-1:0] cmd_len;

    frame_burst_sequencer #(.LSIZE(LSIZE), .BSIZE(BSIZE), .LENSIZE(LENSIZE),
                            .BURST_LEN(BURST_LEN), .ADDR_SETTLE(AS)) dut (
        .clock(clock), .rst(rst), .enable(enable), .frame_start(frame_start),
        .lines(lines), .bursts_per_line(bursts_per_line), .tail_len(tail_len),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_last_line(cmd_last_line), .cmd_last_frame(cmd_last_frame),
        .burst_resp(burst_resp), .new_base(new_base), .burst_done(burst_done),
        .tail_done(tail_done), .frame_done(frame_done), .busy(busy));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [LENSIZE-1:0] len;
        logic               ll;
        logic               lf;
    } cmd_t;

    cmd_t exp_cmd[$];
    int   exp_str[$];   // 0 new_base, 1 burst_done, 2 tail_done, 3 frame_done
    int   checks = 0, passes = 0;

    // knobs for the data-mover model
    int   ready_pct = 100, dmin = 1, dmax = 1;
    logic hold_low = 0, force_resp = 0, rand_en = 0, en_req = 0, tchk = 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference: expected command/strobe stream of one frame.
    task automatic model(input int l, input int b, input int t);
        int n;
        cmd_t c;
        n = b + ((t != 0) ? 1 : 0);
        exp_str.push_back(0);
        if (l != 0 && n != 0) begin
            for (int li = 0; li < l; li++) begin
                for (int bi = 0; bi < n; bi++) begin
                    c.len = (t != 0 && bi == n - 1) ? LENSIZE'(t) : LENSIZE'(BURST_LEN);
                    c.ll  = (bi == n - 1);
                    c.lf  = c.ll && (li == l - 1);
                    exp_cmd.push_back(c);
                    exp_str.push_back(c.ll ? 2 : 1);
                end
            end
        end
        exp_str.push_back(3);
    endtask

    // Data mover: ready, response timing and enable, updated after the edge.
    initial begin
        int   timer;
        logic acc, fire;
        timer = 0;
        forever begin
            @(negedge clock);
            acc = cmd_valid && cmd_ready && !rst;
            @(posedge clock);
            #2;
            fire = 0;
            if (rst) timer = 0;
            else begin
                if (acc) timer = $urandom_range(dmax, dmin);
                if (timer > 0) begin
                    timer--;
                    if (timer == 0) fire = 1;
                end
            end
            burst_resp = fire | force_resp;
            cmd_ready  = !hold_low && ($urandom_range(99, 0) < ready_pct);
            enable     = rand_en ? ($urandom_range(99, 0) < 75) : en_req;
        end
    end

    // Monitor: scoreboard pops, latency, spacing and hold checks.
    initial begin
        int   anchor, anchor_t, last_done, prev_f, code;
        logic have_done, pend, pv;
        anchor = 0; anchor_t = 0; last_done = 0; prev_f = 0;
        have_done = 0; pend = 0; pv = 0;
        forever begin
            @(negedge clock);
            if (rst) begin
                anchor = 0; have_done = 0; pend = 0; pv = 0;
            end else begin
                if (frame_start && !busy) begin anchor = 1; anchor_t = cyc; end
                if (burst_resp && !force_resp) begin anchor = 2; anchor_t = cyc; end
                for (int s = 0; s < 4; s++) begin
                    if ((s == 0 && new_base) || (s == 1 && burst_done) ||
                        (s == 2 && tail_done) || (s == 3 && frame_done)) begin
                        code = s;
                        if (exp_str.size() == 0) chk("strobe_unexpected", code, -1);
                        else chk("strobe_order", code, exp_str.pop_front());
                        if (s == 0) begin
                            if (anchor == 1) chk("new_base_latency", cyc - anchor_t, 1);
                            have_done = 0;
                        end else if (s < 3) begin
                            if (anchor == 2) chk("strobe_latency", cyc - anchor_t, 1);
                            if (have_done) chk("strobe_spacing", int'(cyc - last_done - 1 >= AS + 2), 1);
                            have_done = 1;
                            last_done = cyc;
                        end else begin
                            if (anchor != 0) chk("frame_done_latency", cyc - anchor_t, 2);
                            anchor = 0;
                        end
                    end
                end
                if (pend) begin
                    chk("valid_held", int'(cmd_valid), 1);
                    chk("fields_stable", int'({cmd_len, cmd_last_line, cmd_last_frame}), prev_f);
                end
                if (cmd_valid && !pv) begin
                    chk("raise_needs_enable", int'(enable), 1);
                    if (tchk && anchor != 0)
                        chk("issue_latency", cyc - anchor_t, (anchor == 1) ? 2 : 2 + AS);
                    anchor = 0;
                end
                if (cmd_valid && cmd_ready) begin
                    if (exp_cmd.size() == 0) chk("cmd_unexpected", int'(cmd_len), -1);
                    else begin
                        cmd_t e;
                        e = exp_cmd.pop_front();
                        chk("cmd_len", int'(cmd_len), int'(e.len));
                        chk("cmd_last_line", int'(cmd_last_line), int'(e.ll));
                        chk("cmd_last_frame", int'(cmd_last_frame), int'(e.lf));
                    end
                end
                pend   = cmd_valid && !cmd_ready;
                prev_f = int'({cmd_len, cmd_last_line, cmd_last_frame});
                pv     = cmd_valid;
            end
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_cmd.size() != 0 || exp_str.size() != 0) && n < 4000) begin
            @(posedge clock);
            n++;
        end
        chk("frame_complete", int'(n < 4000), 1);
        exp_cmd.delete();
        exp_str.delete();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input int l, input int b, input int t);
        @(posedge clock);
        #1;
        model(l, b, t);
        lines = LSIZE'(l); bursts_per_line = BSIZE'(b); tail_len = LENSIZE'(t);
        frame_start = 1;
        @(posedge clock);
        #1;
        frame_start = 0;
    endtask

    // hold: extra cycles frame_start stays high; fr: force burst_resp in IDLE/BASE
    task automatic run_frame(input int l, input int b, input int t, input int hold, input int fr);
        @(posedge clock);
        #1;
        model(l, b, t);
        lines = LSIZE'(l); bursts_per_line = BSIZE'(b); tail_len = LENSIZE'(t);
        frame_start = 1;
        force_resp  = (fr != 0);
        @(posedge clock);
        #1;
        if (hold < 1) frame_start = 0;
        @(posedge clock);
        #1;
        force_resp = 0;
        if (hold < 2) frame_start = 0;
        @(posedge clock);
        #1;
        frame_start = 0;
        wait_done();
    endtask

    initial begin
        int n;
        #12;
        chk("rst_outputs", int'({cmd_valid, cmd_last_line, cmd_last_frame, new_base,
                                 burst_done, tail_done, frame_done}), 0);
        chk("rst_cmd_len", int'(cmd_len), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clock);
        #1;
        rst = 0;
        en_req = 1;

        run_frame(2, 3, 0, 0, 0);    // basic
        run_frame(1, 2, 17, 0, 0);   // tail
        run_frame(1, 2, 0, 0, 1);    // spacing, stray burst_resp in IDLE/BASE
        run_frame(0, 4, 9, 2, 0);    // empty frame, frame_start while busy

        // backpressure: ready low for 10 cycles, enable dropped mid-wait
        hold_low = 1;
        pulse_start(1, 1, 0);
        n = 0;
        while (!cmd_valid && n < 20) begin @(negedge clock); n++; end
        chk("bp_valid_raised", int'(n < 20), 1);
        repeat (3) @(posedge clock);
        #1;
        en_req = 0;
        repeat (7) @(posedge clock);
        #1;
        chk("bp_valid_held_10", int'(cmd_valid), 1);
        hold_low = 0;
        wait_done();
        en_req = 1;

        // reset during WAIT
        dmin = 3; dmax = 3;
        pulse_start(2, 2, 5);
        n = 0;
        while (!(cmd_valid && cmd_ready) && n < 30) begin @(negedge clock); n++; end
        chk("rst_test_accept", int'(n < 30), 1);
        @(posedge clock);
        #3;
        rst = 1;
        #1;
        chk("midrst_outputs", int'({cmd_valid, cmd_last_line, cmd_last_frame, new_base,
                                    burst_done, tail_done, frame_done}), 0);
        chk("midrst_cmd_len", int'(cmd_len), 0);
        chk("midrst_busy", int'(busy), 0);
        exp_cmd.delete();
        exp_str.delete();
        repeat (4) @(posedge clock);
        #1;
        rst = 0;
        dmin = 1; dmax = 1;
        run_frame(2, 2, 5, 0, 0);

        // randomized frames with random ready, response delay and enable
        tchk = 0;
        rand_en = 1;
        dmax = 4;
        for (int i = 0; i < 25; i++) begin
            ready_pct = $urandom_range(100, 40);
            run_frame($urandom_range(3, 0), $urandom_range(3, 0),
                      ($urandom_range(1, 0) != 0) ? $urandom_range(255, 1) : 0, 0, 0);
        end
        rand_en = 0;
        repeat (3) @(posedge clock);
        chk("idle_at_end", int'(busy), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/frame_burst_sequencer.md
Name: frame_burst_sequencer

Overview:
- Control stage directly upstream of the per-frame address generator.
- Walks one frame as lines × (full bursts + optional tail burst) and issues one burst command per step to the AXI data mover over a valid/ready handshake.
- After each burst completes, emits the single-cycle new_base / burst_done / tail_done strobes the address generator consumes.
- Waits a programmable settle time so the next command sees the updated address.

Parameters:
- LSIZE, 12: width of line-count input.
- BSIZE, 12: width of full-bursts-per-line input.
- LENSIZE, 8: width of burst length fields, in beats.
- BURST_LEN, 64: beats in a full burst; must be ≥1 and < 2**LENSIZE.
- ADDR_SETTLE, 3: idle cycles after every done strobe before the next cmd_valid; covers the downstream edge-detect plus register latency; must be ≥1.

Ports:
- clock, input, 1: sole clock; all logic on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- enable, input, 1: permits new commands to be raised.
- frame_start, input, 1: one-cycle request to start a frame; honoured only in IDLE.
- lines, input, LSIZE: lines per frame; latched at an accepted frame_start.
- bursts_per_line, input, BSIZE: full bursts per line; latched at an accepted frame_start.
- tail_len, input, LENSIZE: beats in the tail burst, 0 = no tail; latched at an accepted frame_start.
- cmd_valid, output, 1: burst command valid.
- cmd_ready, input, 1: data mover accepts the command.
- cmd_len, output, LENSIZE: beats in the current burst.
- cmd_last_line, output, 1: current burst is the last burst of its line.
- cmd_last_frame, output, 1: current burst is the last burst of the frame.
- burst_resp, input, 1: one-cycle completion of the accepted burst.
- new_base, output, 1: one-cycle strobe, frame base reload.
- burst_done, output, 1: one-cycle strobe, non-last burst of a line completed.
- tail_done, output, 1: one-cycle strobe, last burst of a line completed.
- frame_done, output, 1: one-cycle strobe, frame finished.
- busy, output, 1: high whenever state ≠ IDLE.

Behaviour:
- Reset: async on rst high.
  - State = IDLE; line counter and burst counter = 0; settle counter = 0.
  - All outputs 0, including cmd_len.
  - Reset mid-frame abandons the frame; no strobes follow.
- States and transitions:
  - IDLE: frame_start latches lines, bursts_per_line and tail_len → BASE.
  - BASE: new_base = 1 for this one cycle; counters cleared. If the frame is empty → FEND, else → ISSUE.
  - ISSUE: cmd_valid = 1 while enable = 1. Handshake when cmd_valid && cmd_ready → WAIT.
  - WAIT: cmd_valid = 0; on burst_resp → STROBE.
  - STROBE: one cycle. Asserts tail_done if cmd_last_line, else burst_done. Advances counters. If cmd_last_frame → FEND, else → SETTLE.
  - SETTLE: counts ADDR_SETTLE cycles → ISSUE.
  - FEND: frame_done = 1 for one cycle → IDLE.
- Empty frame: lines = 0, or bursts_per_line = 0 and tail_len = 0.
- Bursts per line: N = bursts_per_line + (tail_len ≠ 0).
- Burst index b in 0..N-1:
  - cmd_len = tail_len if a tail exists and b = N-1, else BURST_LEN.
  - cmd_last_line = (b = N-1).
  - cmd_last_frame = cmd_last_line and (line = lines-1).
- Command field stability:
  - cmd_len and the cmd_last_* flags are registered.
  - They are valid and stable from the first cycle cmd_valid is high through the handshake cycle.
- Handshake rules:
  - Once raised, cmd_valid is never retracted before the handshake, even if enable falls.
  - enable low only prevents raising cmd_valid from ISSUE.
- Unsolicited inputs:
  - burst_resp outside WAIT is ignored, including in the handshake cycle; the data mover responds ≥1 cycle after acceptance.
  - frame_start while busy is ignored.
- Strobe spacing: done strobes are exactly one cycle and always separated by ≥ADDR_SETTLE+2 low cycles, so rising-edge consumers see each one.
- Latency:
  - frame_start at cycle 0 → new_base at cycle 1 → cmd_valid at cycle 2 (enable high).
  - burst_resp sampled at cycle t → strobe at t+1 → next cmd_valid at t+2+ADDR_SETTLE; or frame_done at t+2 for the last burst.
- Counter widths: line counter LSIZE bits, burst counter BSIZE+1 bits; no wrap is possible within legal inputs.

Test Plan:
- Basic frame: lines = 2, bursts_per_line = 3, tail_len = 0, cmd_ready and burst_resp prompt.
  - Expect 6 commands, all with cmd_len = 64.
  - Strobe order: burst_done, burst_done, tail_done, repeated twice.
  - One new_base first, frame_done after the 6th strobe.
- Tail frame: lines = 1, bursts_per_line = 2, tail_len = 17.
  - Expect cmd_len 64, 64, 17.
  - cmd_last_line and cmd_last_frame are set only on the third command; the third strobe is tail_done.
- Backpressure: cmd_ready held low for 10 cycles and enable dropped mid-wait.
  - cmd_valid stays high and cmd_len stays stable until cmd_ready; exactly one command is issued.
- Empty frame: lines = 0.
  - new_base at cycle 1, frame_done at cycle 2, no cmd_valid.
  - A second frame_start while busy is ignored.
- Spacing: ADDR_SETTLE = 3 with burst_resp 1 cycle after each accept.
  - Next cmd_valid is exactly 5 cycles after the sampled burst_resp.
  - burst_resp driven in IDLE and BASE is ignored.
- Reset mid-frame: assert rst asynchronously during WAIT.
  - All outputs go to 0 immediately and state is IDLE.
  - A following frame_start runs a complete frame normally.
